// File: rtl/weighted_rr_arb_if.sv
// Handshake bundle for weighted_rr_arb: N request channels in, one arbitrated stream out.
interface weighted_rr_arb_if #(
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_data_width  = 32,
  parameter int unsigned p_weight_bits = 2
);
  logic [p_num_reqs-1:0]               in_val;
  logic [p_num_reqs-1:0]               in_rdy;
  logic [p_num_reqs*p_data_width-1:0]  in_data;
  logic [p_num_reqs-1:0]               in_last;
  logic [p_num_reqs*p_weight_bits-1:0] weight;
  logic                                out_val;
  logic                                out_rdy;
  logic [p_data_width-1:0]             out_data;
  logic                                out_last;
  logic [p_num_reqs-1:0]               gnt;

  modport slave (
    input  in_val, in_data, in_last, weight, out_rdy,
    output in_rdy, out_val, out_data, out_last, gnt
  );

  modport master (
    output in_val, in_data, in_last, weight, out_rdy,
    input  in_rdy, out_val, out_data, out_last, gnt
  );
endinterface

// File: rtl/weighted_rr_arb.sv
// Burst-locked weighted round-robin arbiter: a winner keeps the bus for a whole burst and
// may win up to weight[i] consecutive bursts before the pointer moves past it.
module weighted_rr_arb #(
  parameter int unsigned p_num_reqs    = 4,
  parameter int unsigned p_data_width  = 32,
  parameter int unsigned p_weight_bits = 2
) (
  input  logic             clk,
  input  logic             rst,
  weighted_rr_arb_if.slave bus
);

  localparam int unsigned LP_IDX_W   = (p_num_reqs > 1) ? $clog2(p_num_reqs) : 1;
  localparam int unsigned LP_CNT_MAX = (1 << p_weight_bits) - 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                   r_state, w_state_nxt;
  logic [LP_IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [LP_IDX_W-1:0]      r_ptr,   w_ptr_nxt;
  logic [LP_IDX_W-1:0]      r_lidx,  w_lidx_nxt;
  logic [p_weight_bits-1:0] r_cnt,   w_cnt_nxt;

  logic                     w_rr_found;
  logic [LP_IDX_W-1:0]      w_rr_idx;
  logic                     w_has_sel;
  logic [LP_IDX_W-1:0]      w_sel;
  logic [p_weight_bits-1:0] w_weight_sel;
  logic [p_weight_bits-1:0] w_weight_eff;
  logic [p_weight_bits:0]   w_n;
  logic                     w_xfer;
  logic                     w_done;

  // (base + off) mod N, with both operands already below N
  function automatic logic [LP_IDX_W-1:0] f_wrap(input logic [LP_IDX_W-1:0] base,
                                                 input int unsigned off);
    int unsigned v;
    v = 32'(base) + off;
    if (v >= p_num_reqs) v = v - p_num_reqs;
    return LP_IDX_W'(v);
  endfunction

  // First requester in scan order ptr, ptr+1, ..., wrapping
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      if (!w_rr_found && bus.in_val[f_wrap(r_ptr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = f_wrap(r_ptr, k);
      end
    end
  end

  assign w_sel     = (r_state == ST_LOCKED) ? r_owner : w_rr_idx;
  assign w_has_sel = !rst && ((r_state == ST_LOCKED) || w_rr_found);

  // Zero-latency mux from the selected channel to the output
  always_comb begin
    bus.gnt      = '0;
    bus.in_rdy   = '0;
    bus.out_val  = 1'b0;
    bus.out_data = '0;
    bus.out_last = 1'b0;
    w_weight_sel = '0;
    for (int unsigned i = 0; i < p_num_reqs; i++) begin
      if (w_has_sel && (w_sel == LP_IDX_W'(i))) begin
        bus.gnt[i]    = 1'b1;
        bus.in_rdy[i] = bus.out_rdy;
        bus.out_val   = bus.in_val[i];
        bus.out_data  = bus.in_data[i*p_data_width +: p_data_width];
        bus.out_last  = bus.in_last[i];
        w_weight_sel  = bus.weight[i*p_weight_bits +: p_weight_bits];
      end
    end
  end

  assign w_xfer       = bus.out_val & bus.out_rdy;
  assign w_done       = w_xfer & bus.out_last;
  assign w_weight_eff = (w_weight_sel == '0) ? p_weight_bits'(1) : w_weight_sel;

  // Consecutive-burst count, saturating at the counter's maximum
  always_comb begin
    w_n = (p_weight_bits+1)'(1);
    if (w_sel == r_lidx) begin
      w_n = {1'b0, r_cnt} + (p_weight_bits+1)'(1);
      if (w_n > (p_weight_bits+1)'(LP_CNT_MAX)) w_n = (p_weight_bits+1)'(LP_CNT_MAX);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_lidx_nxt  = r_lidx;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && !bus.out_last) begin
          w_state_nxt = ST_LOCKED;
          w_owner_nxt = w_sel;
        end
      end
      ST_LOCKED: begin
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_done) begin
      w_lidx_nxt = w_sel;
      if (w_n >= {1'b0, w_weight_eff}) begin
        w_ptr_nxt = f_wrap(w_sel, 1);
        w_cnt_nxt = '0;
      end else begin
        w_ptr_nxt = w_sel;
        w_cnt_nxt = p_weight_bits'(w_n);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_lidx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lidx  <= w_lidx_nxt;
    end
  end

endmodule

// File: doc/weighted_rr_arb.md
WEIGHTED_RR_ARB -- requirements
Module: weighted_rr_arb

Interface
REQ-001 The block SHALL have parameter p_num_reqs, default 4: number of requesting input channels, legal range 2 to 32.
REQ-002 The block SHALL have parameter p_data_width, default 32: payload width per channel.
REQ-003 The block SHALL have parameter p_weight_bits, default 2: width of each per-channel weight field.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_val, input, p_num_reqs bits: per-channel valid.
REQ-007 The block SHALL have port in_rdy, output, p_num_reqs bits: per-channel ready.
REQ-008 The block SHALL have port in_data, input, p_num_reqs*p_data_width bits: channel i occupies bits [i*p_data_width +: p_data_width].
REQ-009 The block SHALL have port in_last, input, p_num_reqs bits: marks the final beat of a burst.
REQ-010 The block SHALL have port weight, input, p_num_reqs*p_weight_bits bits: burst quota per channel, packed in the same way as in_data.
REQ-011 The block SHALL have port out_val, output, 1 bit: output valid.
REQ-012 The block SHALL have port out_rdy, input, 1 bit: output ready.
REQ-013 The block SHALL have port out_data, output, p_data_width bits: output payload.
REQ-014 The block SHALL have port out_last, output, 1 bit: output last-beat marker.
REQ-015 The block SHALL have port gnt, output, p_num_reqs bits: one-hot selected channel, or all zeros when no channel is selected.

Function
REQ-016 State SHALL consist of: FSM {IDLE, LOCKED}; owner index; priority pointer ptr; burst counter cnt (p_weight_bits bits); last-completed index lidx.
REQ-017 A beat SHALL transfer in a cycle exactly when out_val and out_rdy are both high.
REQ-018 IDLE selection SHALL be combinational round-robin: the first channel with in_val high, scanning ptr, ptr+1, and so on up to N-1, then wrapping from 0 to ptr-1.
REQ-019 In IDLE with no in_val set, the block SHALL drive gnt=0 and out_val=0.
REQ-020 In LOCKED, the selected channel SHALL be owner regardless of the other channels' in_val.
REQ-021 The outputs SHALL be driven as gnt = one-hot(selected), out_val = in_val[selected], out_data = in_data[selected], out_last = in_last[selected].
REQ-022 Ready SHALL be driven as in_rdy[selected] = out_rdy, with all other in_rdy bits 0, giving a zero-cycle combinational pass-through with no storage.
REQ-023 In IDLE, a transfer with out_last=0 SHALL move the FSM to LOCKED and set owner to the selected channel.
REQ-024 In LOCKED, a transfer with out_last=1 SHALL move the FSM to IDLE.
REQ-025 In LOCKED, an owner in_val=0 SHALL hold the lock, produce a bubble, and leave the other channels stalled.
REQ-026 On burst completion (a transfer with out_last=1) from channel i, the block SHALL compute n = (i==lidx) ? cnt+1 : 1, saturating at 2^p_weight_bits-1.
REQ-027 On burst completion from channel i, the effective weight SHALL be w = max(weight[i], 1), sampled in the completion cycle; a weight of 0 behaves as 1.
REQ-028 On burst completion, if n >= w then ptr <= (i+1) mod p_num_reqs and cnt <= 0; otherwise ptr <= i and cnt <= n.
REQ-029 On burst completion, lidx SHALL be set to i.
REQ-030 Channel i SHALL therefore receive up to w consecutive bursts while it keeps requesting.
REQ-031 If channel i stops requesting, the scan from ptr=i SHALL pass over it, and its next burst SHALL restart the count at 1.
REQ-032 A single-beat burst (out_last=1 in IDLE) SHALL update ptr, cnt and lidx without entering LOCKED.
REQ-033 Pointer wrap-around from channel N-1 SHALL return ptr to 0.
REQ-034 Changes to weight in the middle of a burst SHALL take effect only at that burst's completion.
REQ-035 in_data, in_last and in_val from non-selected channels SHALL NOT affect any output or state.

Reset
REQ-036 While rst is high, the block SHALL set FSM=IDLE, ptr=0, cnt=0, lidx=0 and owner=0.
REQ-037 While rst is high, the block SHALL force out_val=0, in_rdy=0 and gnt=0 regardless of inputs.
REQ-038 Reset asserted in the middle of a burst SHALL abandon the lock; the first arbitration after reset SHALL prefer channel 0.

Verification (p_num_reqs=4, p_data_width=8, p_weight_bits=2, out_rdy=1 unless stated)
REQ-039 The bench SHALL cover: after reset, in_val=4'b1111, single-beat bursts, weight all 1 -> gnt sequence 0001, 0010, 0100, 1000, 0001.
REQ-040 The bench SHALL cover: weight[0]=3, others 1, all channels requesting single-beat -> grant order 0,0,0,1,2,3,0,0,0.
REQ-041 The bench SHALL cover: ch2 sends a 3-beat burst, ch1 requesting throughout, ch2 in_val low in beat 2 -> gnt stays 0100 for 4 cycles, in_rdy[1]=0 throughout, and ch1 is granted only after ch2's last beat.
REQ-042 The bench SHALL cover: out_rdy=0 for 3 cycles during a burst from ch1 -> out_data holds ch1 data, gnt constant, and no state change.
REQ-043 The bench SHALL cover: rst pulsed during the 2nd beat of a ch3 burst, then in_val=4'b1001 -> gnt=0001 in the first cycle after reset.
REQ-044 The bench SHALL cover: weight[1]=0 with ch1 alone requesting -> every ch1 burst is granted, with ptr advancing to 2 and then scanning back around to 1.
REQ-045 The bench SHALL check, every cycle: gnt is one-hot or zero, in_rdy is a subset of gnt, and out_val == |(gnt & in_val).
